// File: rtl/dual_read_ram_responder.sv
// Two-read / one-write memory responder with a debug preload/inspect port.
// Tracks written entries, forwards same-edge writes to reads, and keeps sticky error flags.
module dual_read_ram_responder #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  output logic [WIDTH-1:0]      rdata0,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [WIDTH-1:0]      rdata1,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] debug_write_addr,
  input  logic [WIDTH-1:0]      debug_write_data,
  input  logic                  debug_write_en,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [WIDTH-1:0]      debug_data,
  output logic                  uninit_read,
  output logic                  addr_error,
  output logic                  wr_collision,
  output logic [15:0]           write_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_X = DEPTH[ADDR_WIDTH:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] written;

  logic        wcommit;
  logic        dcommit;
  logic        collision;
  logic        addr_err_now;
  logic [1:0]  inc;
  logic [16:0] count_sum;
  logic [WIDTH:0] slot0;
  logic [WIDTH:0] slot1;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  // Returns {uninit, data} for one read port, applying write-first forwarding.
  function automatic logic [WIDTH:0] read_slot(input logic [ADDR_WIDTH-1:0] a);
    logic [WIDTH:0] r;
    r = '0;
    if (!in_range(a))
      r = '0;
    else if (wcommit && (waddr == a))
      r = {1'b0, wdata};
    else if (dcommit && (debug_write_addr == a))
      r = {1'b0, debug_write_data};
    else if (!written[a[IDX_W-1:0]])
      r = {1'b1, {WIDTH{1'b0}}};
    else
      r = {1'b0, mem[a[IDX_W-1:0]]};
    return r;
  endfunction

  always_comb begin
    wcommit      = wen && in_range(waddr);
    collision    = wcommit && debug_write_en && in_range(debug_write_addr)
                   && (debug_write_addr == waddr);
    dcommit      = debug_write_en && in_range(debug_write_addr) && !collision;
    addr_err_now = (wen && !in_range(waddr))
                   || (debug_write_en && !in_range(debug_write_addr))
                   || !in_range(raddr0) || !in_range(raddr1);
    inc          = {1'b0, wcommit} + {1'b0, dcommit};
    count_sum    = {1'b0, write_count} + {15'b0, inc};
    slot0        = read_slot(raddr0);
    slot1        = read_slot(raddr1);
  end

  assign debug_data = in_range(debug_addr) ? mem[debug_addr[IDX_W-1:0]] : '0;

  // Array contents survive reset; writes are simply suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (dcommit)
        mem[debug_write_addr[IDX_W-1:0]] <= debug_write_data;
      if (wcommit)
        mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0       <= '0;
      rdata1       <= '0;
      written      <= '0;
      uninit_read  <= 1'b0;
      addr_error   <= 1'b0;
      wr_collision <= 1'b0;
      write_count  <= '0;
    end else begin
      rdata0 <= slot0[WIDTH-1:0];
      rdata1 <= slot1[WIDTH-1:0];
      if (wcommit)
        written[waddr[IDX_W-1:0]] <= 1'b1;
      if (dcommit)
        written[debug_write_addr[IDX_W-1:0]] <= 1'b1;
      if (slot0[WIDTH] || slot1[WIDTH])
        uninit_read <= 1'b1;
      if (addr_err_now)
        addr_error <= 1'b1;
      if (collision)
        wr_collision <= 1'b1;
      write_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end
  end

endmodule
